ysyx_24110015_exu_mc: RTL and testbench
=======================================

// Module: ysyx_24110015_exu_mc
// PURPOSE
//  Multi-cycle, parametrised execute unit; successor to the single-cycle adder-only EXU.
//  Sits between IDU and LSU/WBU and exchanges operations with them over valid/ready handshakes.
//  Provides a full RV32I ALU, branch resolution and next-PC generation.
//  Provides an optional iterative M-extension unit (MUL*/DIV*/REM*).
//  Reports ebreak as a registered trap pulse rather than a combinational call.
// PARAMETERS
//  XLEN    32  datapath width (power of two, >=8); SHW=$clog2(XLEN) is the shift-amount width
//  MDU_EN  1   1: iterative mul/div present; 0: M ops execute as ADD in 1 cycle
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     asynchronous, active-low reset
//  in_valid   in   1     upstream holds a valid operation
//  in_ready   out  1     EXU can accept; 1 only in IDLE
//  pc         in   XLEN  PC of the operation
//  imm        in   XLEN  decoded immediate
//  data1      in   XLEN  rs1 value
//  data2      in   XLEN  rs2 value
//  ALUAsrc    in   2     ALU A select: 00 data1, 01 pc, 1x zero
//  ALUBsrc    in   2     ALU B select: 00 data2, 01 imm, 10 constant 4, 11 zero
//  PCAsrc     in   1     target base: 0 pc, 1 data1 (jalr)
//  PCBsrc     in   1     target offset: 0 constant 4, 1 imm
//  alu_op     in   5     operation code (see BEHAVIOUR)
//  br_type    in   3     000 uncond, 001 BEQ, 010 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
//  ebreak     in   1     operation is ebreak
//  flush      in   1     synchronous abort of the current operation
//  out_valid  out  1     result registers valid
//  out_ready  in   1     downstream accepts the result
//  data_out   out  XLEN  ALU/MDU result
//  pc_next    out  XLEN  resolved next PC
//  trap       out  1     1-cycle pulse when an ebreak operation is accepted
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; out_valid=0, trap=0, data_out=0, pc_next=0; MDU counter=0.
//  Handshake:
//   - Accept when in_valid&in_ready; all inputs are sampled only at accept.
//   - Result is transferred when out_valid&out_ready.
//   - data_out/pc_next stay stable while out_valid=1 and out_ready=0.
//  FSM:
//   - IDLE: accept -> DONE (non-MDU op) or BUSY (MDU op with MDU_EN=1).
//   - BUSY: counter runs 0..XLEN-1; at XLEN-1 -> DONE.
//   - DONE: out_valid=1; out_ready -> IDLE. There is no skid: in_ready=0 in DONE, so back-to-back ops are 2 cycles each.
//   - flush in any state -> IDLE next cycle, out_valid=0, MDU state discarded, no trap. flush overrides accept in the same cycle.
//  Latency (accept to out_valid):
//   - Non-MDU ops: 1 cycle.
//   - MDU ops: XLEN+1 cycles. mul uses 1-bit shift-add per cycle; div uses restoring 1-bit per cycle.
//  alu_op encoding; codes 18-31 behave as ADD:
//   - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
//   - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU
//  Arithmetic:
//   - All results are modulo 2^XLEN. Shifts use B[SHW-1:0] only. SLT/SLTU produce 0 or 1.
//   - MUL returns the low XLEN bits of the 2*XLEN product; MULH* return the high XLEN bits with the named signedness.
//  Division corner cases (RISC-V):
//   - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
//   - Signed overflow (A=-2^(XLEN-1), B=-1): DIV = A, REM = 0.
//   - Both cases still take XLEN+1 cycles.
//  Next PC:
//   - taken = (br_type==000) | cmp(data1,data2); the comparison always uses data1/data2, not the ALU muxes.
//   - pc_next = taken ? (PCA+PCB) : pc+4.
//   - If PCAsrc=1, bit0 of pc_next is cleared.
//  ebreak: trap=1 for exactly the cycle after accept. The op then completes normally as a 1-cycle ADD.
//  in_valid while not in IDLE is ignored; upstream must hold its inputs until accepted.
// TESTING
//  1. data1=5, data2=7, ALUAsrc=00, ALUBsrc=00, op SUB
//     -> data_out=0xFFFFFFFE, out_valid 1 cycle after accept, pc_next=pc+4.
//  2. op SRA, A=0x80000000, B=0x24 (shamt 4) -> data_out=0xF8000000.
//     op SLTU, A=1, B=0xFFFFFFFF -> data_out=1.
//  3. pc=0x80000000, imm=0x10, PCBsrc=1, BEQ with data1=data2=3 -> pc_next=0x80000010.
//     Same op with data2=4 -> pc_next=0x80000004.
//  4. MULH with 0xFFFFFFFF x 0xFFFFFFFF -> data_out=0, out_valid after 33 cycles.
//     DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REMU 9 / 0 -> 9.
//  5. MUL accepted, flush asserted at busy cycle 10 -> IDLE next cycle, no out_valid.
//     Then ADD 1+2 -> data_out=3.
//  6. ebreak accepted -> trap=1 for one cycle.
//     Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0.
//     Assert rst=0 mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_24110015_exu_mc_if.sv
// ysyx_24110015_exu_mc_if: operation handshake between IDU, EXU and LSU/WBU
// master: upstream/downstream side driving operations and consuming results
// slave : execute unit side
interface ysyx_24110015_exu_mc_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [1:0]      ALUAsrc;
  logic [1:0]      ALUBsrc;
  logic            PCAsrc;
  logic            PCBsrc;
  logic [4:0]      alu_op;
  logic [2:0]      br_type;
  logic            ebreak;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] data_out;
  logic [XLEN-1:0] pc_next;
  logic            trap;
  modport master (
    output in_valid, pc, imm, data1, data2, ALUAsrc, ALUBsrc, PCAsrc, PCBsrc,
           alu_op, br_type, ebreak, flush, out_ready,
    input  in_ready, out_valid, data_out, pc_next, trap
  );
  modport slave (
    input  in_valid, pc, imm, data1, data2, ALUAsrc, ALUBsrc, PCAsrc, PCBsrc,
           alu_op, br_type, ebreak, flush, out_ready,
    output in_ready, out_valid, data_out, pc_next, trap
  );
endinterface

// File: rtl/ysyx_24110015_exu_mc.sv
// ysyx_24110015_exu_mc: multi-cycle RV32I execute unit with optional iterative M-extension
// clk   : clock, all state on posedge
// rst_n : asynchronous active-low reset
// bus   : slave side of the operation/result valid-ready interface (plus flush and trap)
module ysyx_24110015_exu_mc #(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  ysyx_24110015_exu_mc_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e            state_q, state_d;
  logic [XLEN-1:0]   a, b, alu, tgt, pcn, ma, mb, fin, q, r;
  logic [XLEN-1:0]   data_q, data_d, pcn_q, a_q, mc_q;
  logic [2*XLEN-1:0] p_q, p_d, prod;
  logic [XLEN:0]     sum, sh, diff;
  logic [SHW-1:0]    cnt_q, shamt;
  logic [2:0]        mop, mop_q;
  logic              acc, is_m, sa, sb, neg_q, z_q, taken, cmp, trap_q, last;
  assign a     = bus.ALUAsrc[1] ? '0 : bus.ALUAsrc[0] ? bus.pc : bus.data1;
  assign b     = bus.ALUBsrc[1] ? (bus.ALUBsrc[0] ? '0 : XLEN'(4)) : (bus.ALUBsrc[0] ? bus.imm : bus.data2);
  assign shamt = b[SHW-1:0];
  always_comb begin
    case (bus.alu_op)
      5'd1:    alu = a - b;
      5'd2:    alu = a << shamt;
      5'd3:    alu = XLEN'($signed(a) < $signed(b));
      5'd4:    alu = XLEN'(a < b);
      5'd5:    alu = a ^ b;
      5'd6:    alu = a >> shamt;
      5'd7:    alu = $signed(a) >>> shamt;
      5'd8:    alu = a | b;
      5'd9:    alu = a & b;
      default: alu = a + b;
    endcase
    if (bus.ebreak) alu = a + b;
  end
  always_comb begin
    case (bus.br_type)
      3'b001:  cmp = bus.data1 == bus.data2;
      3'b010:  cmp = bus.data1 != bus.data2;
      3'b100:  cmp = $signed(bus.data1) < $signed(bus.data2);
      3'b101:  cmp = $signed(bus.data1) >= $signed(bus.data2);
      3'b110:  cmp = bus.data1 < bus.data2;
      3'b111:  cmp = bus.data1 >= bus.data2;
      default: cmp = 1'b0;
    endcase
  end
  assign taken = (bus.br_type == 3'b000) | cmp;
  assign tgt   = (bus.PCAsrc ? bus.data1 : bus.pc) + (bus.PCBsrc ? bus.imm : XLEN'(4));
  assign pcn   = (taken ? tgt : bus.pc + XLEN'(4)) & ~XLEN'(bus.PCAsrc);
  // M ops are run on operand magnitudes; the sign is re-applied once the iteration ends.
  // mop: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
  assign mop  = 3'(bus.alu_op - 5'd10);
  assign is_m = MDU_EN && bus.alu_op >= 5'd10 && bus.alu_op <= 5'd17 && !bus.ebreak;
  assign sa   = (mop == 3'd1 || mop == 3'd2 || mop == 3'd4 || mop == 3'd6) && a[XLEN-1];
  assign sb   = (mop == 3'd1 || mop == 3'd4 || mop == 3'd6) && b[XLEN-1];
  assign ma   = sa ? -a : a;
  assign mb   = sb ? -b : b;
  // Shared {hi,lo} register: shift-add multiply shifts right, restoring divide shifts left.
  assign sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, mc_q} : '0);
  assign sh   = p_q[2*XLEN-1:XLEN-1];
  assign diff = sh - {1'b0, mc_q};
  assign p_d  = !mop_q[2] ? {sum, p_q[XLEN-1:1]}
              : diff[XLEN] ? {sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
  assign prod = neg_q ? -p_d : p_d;
  assign q    = p_d[XLEN-1:0];
  assign r    = p_d[2*XLEN-1:XLEN];
  assign fin  = !mop_q[2] ? (mop_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
              : z_q ? (mop_q[1] ? a_q : '1)
              : mop_q[1] ? (neg_q ? -r : r) : (neg_q ? -q : q);
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.data_out  = data_q;
  assign bus.pc_next   = pcn_q;
  assign bus.trap      = trap_q;
  assign acc  = bus.in_valid & bus.in_ready & ~bus.flush;
  assign last = state_q == BUSY && cnt_q == SHW'(XLEN - 1);
  assign data_d = (acc && !is_m) ? alu : last ? fin : data_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = is_m ? BUSY : DONE;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      pcn_q   <= '0;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      mc_q    <= '0;
      mop_q   <= '0;
      neg_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      trap_q  <= acc & bus.ebreak;
      cnt_q   <= (state_q == BUSY && !bus.flush) ? cnt_q + SHW'(1) : '0;
      if (acc) begin
        pcn_q <= pcn;
        p_q   <= {{XLEN{1'b0}}, ma};
        a_q   <= a;
        mc_q  <= mb;
        mop_q <= mop;
        neg_q <= (mop[2] && mop[1]) ? sa : sa ^ sb;
        z_q   <= b == '0;
      end else if (state_q == BUSY) begin
        p_q <= p_d;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24110015_exu_mc.sv
// tb_ysyx_24110015_exu_mc: directed plus randomized checks of the execute unit against a reference model
module tb_ysyx_24110015_exu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errs = 0;
  logic [2:0] brs [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
  ysyx_24110015_exu_mc_if #(.XLEN(32)) bus();
  ysyx_24110015_exu_mc #(.XLEN(32), .MDU_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'(sa >>> b[4:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      5'd11: begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
      5'd12: begin p = 64'(longint'(sa) * longint'({32'd0, b})); return p[63:32]; end
      5'd13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd14: return b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      5'd15: return b == 0 ? 32'hFFFFFFFF : a / b;
      5'd16: return b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
      5'd17: return b == 0 ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] ref_pc(input logic [31:0] pc, imm, d1, d2, input logic pa, pb, input logic [2:0] bt);
    logic t;
    logic [31:0] n;
    t = bt == 3'd0 || (bt == 3'd1 && d1 == d2) || (bt == 3'd2 && d1 != d2)
      || (bt == 3'd4 && $signed(d1) < $signed(d2)) || (bt == 3'd5 && $signed(d1) >= $signed(d2))
      || (bt == 3'd6 && d1 < d2) || (bt == 3'd7 && d1 >= d2);
    n = t ? (pa ? d1 : pc) + (pb ? imm : 32'd4) : pc + 32'd4;
    if (pa) n[0] = 1'b0;
    return n;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] pc, imm, d1, d2, input logic [1:0] as, bs,
                       input logic pa, pb, input logic [2:0] bt, input logic eb);
    bus.alu_op = op; bus.pc = pc; bus.imm = imm; bus.data1 = d1; bus.data2 = d2;
    bus.ALUAsrc = as; bus.ALUBsrc = bs; bus.PCAsrc = pa; bus.PCBsrc = pb;
    bus.br_type = bt; bus.ebreak = eb; bus.in_valid = 1'b1;
  endtask

  task automatic scramble();
    bus.alu_op = 5'($urandom); bus.pc = $urandom; bus.imm = $urandom; bus.data1 = $urandom;
    bus.data2 = $urandom; bus.ALUAsrc = 2'($urandom); bus.ALUBsrc = 2'($urandom);
    bus.PCAsrc = 1'($urandom); bus.PCBsrc = 1'($urandom); bus.br_type = 3'($urandom);
    bus.ebreak = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] pc, imm, d1, d2, input logic [1:0] as, bs,
                        input logic pa, pb, input logic [2:0] bt, input logic eb, input int stall);
    logic [31:0] a, b, ed, ep;
    int lat, elat;
    a = as[1] ? 32'd0 : as[0] ? pc : d1;
    b = bs == 2'd0 ? d2 : bs == 2'd1 ? imm : bs == 2'd2 ? 32'd4 : 32'd0;
    ed = eb ? a + b : ref_data(op, a, b);
    ep = ref_pc(pc, imm, d1, d2, pa, pb, bt);
    elat = (!eb && op >= 5'd10 && op <= 5'd17) ? 33 : 1;
    drive(op, pc, imm, d1, d2, as, bs, pa, pb, bt, eb);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    scramble();
    chk("trap", 32'(bus.trap), 32'(eb));
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("data_out", bus.data_out, ed);
    chk("pc_next", bus.pc_next, ep);
    repeat (stall) begin
      @(negedge clk);
      chk("stall_data", bus.data_out, ed);
      chk("stall_pc", bus.pc_next, ep);
      chk("stall_hs", {bus.out_valid, bus.in_ready, bus.trap}, 32'b100);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("released", {bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    scramble();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out", {bus.out_valid, bus.trap, bus.in_ready}, 32'b001);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_pc", bus.pc_next, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(5'd1, 32'h1000, 32'd0, 32'd5, 32'd7, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    run_op(5'd7, 32'h1000, 32'd0, 32'h80000000, 32'h24, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    run_op(5'd4, 32'h1000, 32'd0, 32'd1, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    run_op(5'd0, 32'h80000000, 32'h10, 32'd3, 32'd3, 2'b01, 2'b01, 1'b0, 1'b1, 3'b001, 1'b0, 0);
    run_op(5'd0, 32'h80000000, 32'h10, 32'd3, 32'd4, 2'b01, 2'b01, 1'b0, 1'b1, 3'b001, 1'b0, 0);
    run_op(5'd0, 32'h200, 32'h7, 32'h1001, 32'd0, 2'b01, 2'b10, 1'b1, 1'b1, 3'b000, 1'b0, 0);
    run_op(5'd11, 32'h0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    run_op(5'd14, 32'h0, 32'd0, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    run_op(5'd16, 32'h0, 32'd0, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    run_op(5'd17, 32'h0, 32'd0, 32'd9, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    run_op(5'd14, 32'h0, 32'd0, 32'hFFFFFFF7, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    // flush while busy: no result, back to idle
    drive(5'd10, 32'h0, 32'd0, 32'd6, 32'd7, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0);
    @(negedge clk);
    scramble();
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_idle", {bus.out_valid, bus.in_ready}, 32'b01);
    repeat (40) @(negedge clk);
    chk("flush_no_result", {bus.out_valid, bus.in_ready}, 32'b01);
    run_op(5'd0, 32'h0, 32'd0, 32'd1, 32'd2, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 0);
    // flush in the accept cycle wins: nothing accepted, no trap
    drive(5'd0, 32'h0, 32'd0, 32'd1, 32'd1, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    scramble();
    chk("flush_accept", {bus.out_valid, bus.in_ready, bus.trap}, 32'b010);
    run_op(5'd9, 32'h40, 32'd8, 32'd20, 32'd22, 2'b00, 2'b01, 1'b0, 1'b0, 3'b000, 1'b1, 5);
    for (int i = 0; i < 300; i++)
      run_op(5'($urandom), pick(), pick(), pick(), pick(), 2'($urandom), 2'($urandom), 1'($urandom),
             1'($urandom), brs[$urandom_range(0, 6)], $urandom_range(0, 9) == 0, $urandom_range(0, 2));
    // asynchronous reset in the middle of a multi-cycle op
    drive(5'd10, 32'h100, 32'd0, 32'd6, 32'd7, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    scramble();
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hs", {bus.out_valid, bus.trap, bus.in_ready}, 32'b001);
    chk("arst_data", bus.data_out, 32'd0);
    chk("arst_pc", bus.pc_next, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(5'd13, 32'h0, 32'd0, 32'hFFFFFFFF, 32'd2, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
